// File: rtl/fetch_branch_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit counters.
// Decode's resolved branches train the BTB and redirect fetch on a mispredict.
`timescale 1ns/1ps
module fetch_branch_predictor #(
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ID_branch,
    input  logic [15:0] ID_PC_curr,
    input  logic        ID_pred_taken,
    input  logic [15:0] ID_pred_target,
    input  logic        Branch_taken,
    input  logic [15:0] PC_branch,
    output logic [15:0] PC_curr,
    output logic [15:0] PC_next,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    output logic        mispredict
);
    localparam int TAG_W   = 15 - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;

    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [1:0]       cnt    [ENTRIES];
    logic [15:0]      target [ENTRIES];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             hit;
    logic             upd_hit;
    logic [15:0]      redirect_pc;

    always_comb begin
        idx     = PC_curr[IDX_W:1];
        pc_tag  = PC_curr[15:IDX_W+1];
        upd_idx = ID_PC_curr[IDX_W:1];
        upd_tag = ID_PC_curr[15:IDX_W+1];
        hit     = valid[idx] & (tag[idx] == pc_tag);
        upd_hit = valid[upd_idx] & (tag[upd_idx] == upd_tag);
    end

    // Outputs are forced to their reset values while rst is held.
    always_comb begin
        PC_next     = PC_curr + 16'd2;
        pred_taken  = 1'b0;
        pred_target = '0;
        mispredict  = 1'b0;
        if (!rst) begin
            pred_taken  = hit & cnt[idx][1];
            pred_target = hit ? target[idx] : PC_next;
            mispredict  = ID_branch & ((Branch_taken != ID_pred_taken) |
                                       (Branch_taken & (PC_branch != ID_pred_target)));
        end
        redirect_pc = Branch_taken ? PC_branch : ID_PC_curr + 16'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_curr <= '0;
        end else if (mispredict) begin
            PC_curr <= redirect_pc;
        end else if (stall) begin
            PC_curr <= PC_curr;
        end else if (pred_taken) begin
            PC_curr <= pred_target;
        end else begin
            PC_curr <= PC_next;
        end
    end

    // Training ignores stall; a taken miss overwrites whatever lives in the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '{default: 1'b0};
            tag    <= '{default: '0};
            cnt    <= '{default: 2'b01};
            target <= '{default: '0};
        end else if (ID_branch) begin
            if (upd_hit) begin
                if (Branch_taken) begin
                    if (cnt[upd_idx] != 2'b11) cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
                    target[upd_idx] <= PC_branch;
                end else if (cnt[upd_idx] != 2'b00) begin
                    cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
                end
            end else if (Branch_taken) begin
                valid[upd_idx]  <= 1'b1;
                tag[upd_idx]    <= upd_tag;
                cnt[upd_idx]    <= 2'b10;
                target[upd_idx] <= PC_branch;
            end
        end
    end
endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Self-checking bench: directed vector table, reset sequence, then random
// stimulus against an address-keyed behavioural model of the predictor.
`timescale 1ns/1ps
module tb_fetch_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, ID_branch, ID_pred_taken, Branch_taken;
    logic [15:0] ID_PC_curr, ID_pred_target, PC_branch;
    logic [15:0] PC_curr, PC_next, pred_target;
    logic        pred_taken, mispredict;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_branch_predictor #(.IDX_W(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ID_branch(ID_branch),
        .ID_PC_curr(ID_PC_curr), .ID_pred_taken(ID_pred_taken),
        .ID_pred_target(ID_pred_target), .Branch_taken(Branch_taken),
        .PC_branch(PC_branch), .PC_curr(PC_curr), .PC_next(PC_next),
        .pred_taken(pred_taken), .pred_target(pred_target), .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    // Model: 8 slots chosen by (addr/2)%8, each remembering the branch address that owns it.
    logic [15:0] m_pc;
    bit          m_valid [8];
    logic [15:0] m_owner [8];
    int          m_str   [8];
    logic [15:0] m_tgt   [8];

    function automatic int slot(input logic [15:0] a);
        return (int'(a) / 2) % 8;
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        int s = slot(a);
        return m_valid[s] && (int'(m_owner[s]) / 16 == int'(a) / 16);
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_owner[i] = 16'h0; m_str[i] = 1; m_tgt[i] = 16'h0;
        end
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input logic s, input logic b, input logic [15:0] ipc,
                             input logic ipt, input logic [15:0] itgt,
                             input logic t, input logic [15:0] pb,
                             output logic o_pt, output logic o_mp, output logic [15:0] o_pc);
        int          e;
        bit          h, e_pt, e_mp;
        logic [15:0] e_tgt, e_nxt;
        stall = s; ID_branch = b; ID_PC_curr = ipc; ID_pred_taken = ipt;
        ID_pred_target = itgt; Branch_taken = t; PC_branch = pb;
        @(negedge clk);
        e     = slot(m_pc);
        h     = m_hit(m_pc);
        e_pt  = h && (m_str[e] >= 2);
        e_tgt = h ? m_tgt[e] : m_pc + 16'd2;
        e_mp  = b && ((t != ipt) || (t && pb != itgt));
        if (e_mp)      e_nxt = t ? pb : ipc + 16'd2;
        else if (s)    e_nxt = m_pc;
        else if (e_pt) e_nxt = e_tgt;
        else           e_nxt = m_pc + 16'd2;
        check("pc_curr", PC_curr, m_pc);
        check("pc_next", PC_next, m_pc + 16'd2);
        check("pred_taken", {15'd0, pred_taken}, {15'd0, e_pt});
        check("pred_target", pred_target, e_tgt);
        check("mispredict", {15'd0, mispredict}, {15'd0, e_mp});
        o_pt = pred_taken;
        o_mp = mispredict;
        @(posedge clk);
        if (b) begin
            e = slot(ipc);
            if (m_hit(ipc)) begin
                if (t) begin
                    m_str[e] = (m_str[e] < 3) ? m_str[e] + 1 : 3;
                    m_tgt[e] = pb;
                end else begin
                    m_str[e] = (m_str[e] > 0) ? m_str[e] - 1 : 0;
                end
            end else if (t) begin
                m_valid[e] = 1; m_owner[e] = ipc; m_str[e] = 2; m_tgt[e] = pb;
            end
        end
        m_pc = e_nxt;
        #1;
        o_pc = PC_curr;
    endtask

    typedef struct {
        logic        s, b;
        logic [15:0] ipc;
        logic        ipt;
        logic [15:0] itgt;
        logic        t;
        logic [15:0] pb;
        logic        exp_pt, exp_mp;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] ipc,
                                input logic ipt, input logic [15:0] itgt, input logic t,
                                input logic [15:0] pb, input logic ept, input logic emp,
                                input logic [15:0] epc);
        vec_t v;
        v.s = s; v.b = b; v.ipc = ipc; v.ipt = ipt; v.itgt = itgt; v.t = t; v.pb = pb;
        v.exp_pt = ept; v.exp_mp = emp; v.exp_pc = epc;
        return v;
    endfunction

    task automatic reset_outputs_check(input string tag);
        check({tag, "_pc_curr"}, PC_curr, 16'h0000);
        check({tag, "_pc_next"}, PC_next, 16'h0002);
        check({tag, "_pred_taken"}, {15'd0, pred_taken}, 16'h0000);
        check({tag, "_pred_target"}, pred_target, 16'h0000);
        check({tag, "_mispredict"}, {15'd0, mispredict}, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        o_pt, o_mp;
        logic [15:0] o_pc;
        logic [15:0] pcs  [6];
        logic [15:0] tgts [4];
        pcs  = '{16'h0010, 16'h0110, 16'h0012, 16'h001E, 16'h0F10, 16'hFFFE};
        tgts = '{16'h0010, 16'h0040, 16'h0110, 16'h0200};

        //        s  b  id_pc     ipt itgt      t  pb        pt mp next_pc
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0006));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0008));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0008));
        vecs.push_back(mk(0, 1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 0, 1, 16'h0040));
        vecs.push_back(mk(0, 1, 16'h000E, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'h0010));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0040));
        vecs.push_back(mk(0, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040, 0, 0, 16'h0042));
        vecs.push_back(mk(0, 1, 16'h0010, 1, 16'h0040, 0, 16'h0000, 0, 1, 16'h0012));
        vecs.push_back(mk(0, 1, 16'h0010, 1, 16'h0040, 0, 16'h0000, 0, 1, 16'h0012));
        vecs.push_back(mk(0, 1, 16'h0010, 0, 16'h0040, 0, 16'h0000, 0, 0, 16'h0014));
        vecs.push_back(mk(0, 1, 16'h0010, 0, 16'h0040, 0, 16'h0000, 0, 0, 16'h0016));
        vecs.push_back(mk(0, 1, 16'h000E, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0010));
        vecs.push_back(mk(0, 1, 16'h0010, 0, 16'h0040, 1, 16'h0040, 0, 1, 16'h0040));
        vecs.push_back(mk(0, 1, 16'h000E, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0010));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0012));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0012));
        vecs.push_back(mk(1, 1, 16'h000E, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0010));
        vecs.push_back(mk(1, 1, 16'h0010, 0, 16'h0040, 1, 16'h0040, 0, 1, 16'h0040));
        vecs.push_back(mk(0, 1, 16'h000E, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0010));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0040));
        vecs.push_back(mk(0, 1, 16'hFFFC, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'hFFFE));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 16'h0010, 1, 16'h0040, 1, 16'h0080, 0, 1, 16'h0080));
        vecs.push_back(mk(0, 1, 16'h0110, 0, 16'h0000, 1, 16'h0200, 0, 1, 16'h0200));
        vecs.push_back(mk(0, 1, 16'h000E, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0010));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0012));
        vecs.push_back(mk(0, 1, 16'h010E, 1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0110));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0200));

        rst = 1'b1; stall = 0; ID_branch = 0; ID_PC_curr = '0; ID_pred_taken = 0;
        ID_pred_target = '0; Branch_taken = 0; PC_branch = '0;
        model_reset();
        #12;
        reset_outputs_check("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            run_cycle(vecs[i].s, vecs[i].b, vecs[i].ipc, vecs[i].ipt, vecs[i].itgt,
                      vecs[i].t, vecs[i].pb, o_pt, o_mp, o_pc);
            check($sformatf("tbl_pred_taken[%0d]", i), {15'd0, o_pt}, {15'd0, vecs[i].exp_pt});
            check($sformatf("tbl_mispredict[%0d]", i), {15'd0, o_mp}, {15'd0, vecs[i].exp_mp});
            check($sformatf("tbl_pc_after[%0d]", i), o_pc, vecs[i].exp_pc);
        end

        // Mid-run reset: async clear, held through an edge, then retrained entries are gone.
        stall = 0; ID_branch = 0;
        #2 rst = 1'b1;
        #1 reset_outputs_check("midrst");
        @(posedge clk);
        #1 reset_outputs_check("midrst_edge");
        rst = 1'b0;
        model_reset();
        run_cycle(0, 1, 16'h010E, 1, 16'h0000, 0, 16'h0000, o_pt, o_mp, o_pc);
        check("post_rst_redirect", o_pc, 16'h0110);
        run_cycle(0, 1, 16'h000E, 1, 16'h0000, 0, 16'h0000, o_pt, o_mp, o_pc);
        check("post_rst_0110_pred", {15'd0, o_pt}, 16'h0000);
        run_cycle(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, o_pt, o_mp, o_pc);
        check("post_rst_0010_pred", {15'd0, o_pt}, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            run_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                      pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      tgts[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                      tgts[$urandom_range(0, 3)], o_pt, o_mp, o_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
